// File: rtl/xdma_pkg.sv
// Shared types and constants for the DMA GIF read-response path.
package xdma_pkg;

  // Read-response FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } xdma_rd_state_e;

  // DMA modes served by this engine
  localparam logic [3:0] XDMA_MODE_IOB02M = 4'b0011;
  localparam logic [3:0] XDMA_MODE_IOB12M = 4'b0100;

  // Default widths; an IOB line carries exactly two GIF beats
  localparam int XDMA_DWIDTH = 128;
  localparam int XDMA_DW_IOB = 256;
  localparam bit XDMA_DW_OK  = (XDMA_DW_IOB == 2 * XDMA_DWIDTH);

  function automatic logic xdma_mode_valid(input logic [3:0] mode);
    return (mode == XDMA_MODE_IOB02M) || (mode == XDMA_MODE_IOB12M);
  endfunction

endpackage

// File: rtl/xdma_line_buf.sv
// One-line buffer for IOB read data: 256-bit data register, half-select mux
// and, when XDMA_RD_LINEBUF_EN is defined, a (bank, line, valid) tag with hit
// compare. Without the macro the buffer only holds the captured line and
// never reports a hit.
module xdma_line_buf
  import xdma_pkg::*;
#(
  parameter int DWIDTH = XDMA_DWIDTH,
  parameter int DW_IOB = XDMA_DW_IOB,
  parameter int AW_IOB = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DW_IOB-1:0] cap_data,
  input  logic              cap_bank,
  input  logic [AW_IOB-1:0] cap_line,
  input  logic              inval,
  input  logic              lu_bank,
  input  logic [AW_IOB-1:0] lu_line,
  input  logic              half_sel,
  output logic              hit,
  output logic [DWIDTH-1:0] half_data
);

  logic [DW_IOB-1:0] data_q;

  // Data register: loaded on every capture, even one that coincides with an invalidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else if (capture) data_q <= cap_data;
  end

  assign half_data = half_sel ? data_q[DW_IOB-1:DWIDTH] : data_q[DWIDTH-1:0];

`ifdef XDMA_RD_LINEBUF_EN
  logic              valid_q;
  logic              tag_bank_q;
  logic [AW_IOB-1:0] tag_line_q;

  // Tag and valid: an invalidate always wins over a capture for the valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      tag_bank_q <= 1'b0;
      tag_line_q <= '0;
    end else begin
      if (capture) begin
        tag_bank_q <= cap_bank;
        tag_line_q <= cap_line;
      end
      if (inval) valid_q <= 1'b0;
      else if (capture) valid_q <= 1'b1;
    end
  end

  // A write in the lookup cycle makes the buffered copy suspect, so no hit then
  assign hit = valid_q && !inval && (tag_bank_q == lu_bank) && (tag_line_q == lu_line);
`else
  logic unused_lb;
  assign unused_lb = ^{cap_bank, cap_line, inval, lu_bank, lu_line};
  assign hit = 1'b0;
`endif

endmodule

// File: rtl/xdma_iob_rd_downsize.sv
// Read-response engine: serves 128-bit GIF read beats out of the 256-bit
// IOB0/IOB1 SRAMs (DMA modes 0011/0100). Each miss issues one registered SRAM
// read, waits for dready and returns the selected half-line; hits are served
// from the line buffer when XDMA_RD_LINEBUF_EN is defined.
//
// Handshakes: saccept is combinational in IDLE (mread & valid mode) and the
// request is taken on that cycle's rising edge. svalid/slast/sdata are held
// stable until a cycle with mready high; that edge completes the beat and a
// new request can be accepted from the following cycle.
module xdma_iob_rd_downsize
  import xdma_pkg::*;
#(
  parameter int DWIDTH = XDMA_DWIDTH,
  parameter int DW_IOB = XDMA_DW_IOB,
  parameter int AW_IOB = 12
) (
  input  logic              xclk,
  input  logic              xreset_n,
  input  logic [3:0]        dma_mode,
  input  logic [31:0]       maddr,
  input  logic              mread,
  output logic              saccept,
  output logic              svalid,
  output logic              slast,
  output logic [DWIDTH-1:0] sdata,
  input  logic              mready,
  input  logic              iob_inval,
  output logic [AW_IOB-1:0] iob0_addr,
  output logic              iob0_read,
  output logic              iob0_cs,
  input  logic [DW_IOB-1:0] iob0_rdata,
  input  logic              iob0_dready,
  output logic [AW_IOB-1:0] iob1_addr,
  output logic              iob1_read,
  output logic              iob1_cs,
  input  logic [DW_IOB-1:0] iob1_rdata,
  input  logic              iob1_dready,
  output logic [1:0]        dbg_state
);

  if (!(XDMA_DW_OK && (DW_IOB == 2 * DWIDTH))) begin : g_width_check
    $error("xdma_iob_rd_downsize: DW_IOB must equal 2*DWIDTH");
  end

  xdma_rd_state_e    state_q, state_d;
  logic [AW_IOB-1:0] line_q;
  logic              half_q;
  logic              bank_q;
  logic              req_bank;
  logic              hit;
  logic              dready_sel;
  logic              capture;
  logic [DWIDTH-1:0] half_data;
  logic              unused_addr;

  assign req_bank    = (dma_mode == XDMA_MODE_IOB12M);
  assign dready_sel  = bank_q ? iob1_dready : iob0_dready;
  assign capture     = (state_q == ST_WAIT) && dready_sel;
  assign unused_addr = ^maddr[31:AW_IOB+1];

  // State register
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // Next state, accept and read strobes
  always_comb begin
    state_d   = state_q;
    saccept   = 1'b0;
    iob0_read = 1'b0;
    iob1_read = 1'b0;
    case (state_q)
      ST_IDLE: begin
        saccept = mread && xdma_mode_valid(dma_mode);
        if (saccept) state_d = hit ? ST_RESP : ST_RD;
      end
      ST_RD: begin
        iob0_read = !bank_q;
        iob1_read = bank_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (dready_sel) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (mready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers: line, half and bank are frozen at accept
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      line_q <= '0;
      half_q <= 1'b0;
      bank_q <= 1'b0;
    end else if (saccept) begin
      line_q <= maddr[AW_IOB:1];
      half_q <= maddr[0];
      bank_q <= req_bank;
    end
  end

  xdma_line_buf #(
    .DWIDTH (DWIDTH),
    .DW_IOB (DW_IOB),
    .AW_IOB (AW_IOB)
  ) u_line_buf (
    .clk       (xclk),
    .rst_n     (xreset_n),
    .capture   (capture),
    .cap_data  (bank_q ? iob1_rdata : iob0_rdata),
    .cap_bank  (bank_q),
    .cap_line  (line_q),
    .inval     (iob_inval),
    .lu_bank   (req_bank),
    .lu_line   (maddr[AW_IOB:1]),
    .half_sel  (half_q),
    .hit       (hit),
    .half_data (half_data)
  );

  assign iob0_cs   = iob0_read;
  assign iob1_cs   = iob1_read;
  assign iob0_addr = line_q;
  assign iob1_addr = line_q;
  assign svalid    = (state_q == ST_RESP);
  assign slast     = svalid;
  assign sdata     = svalid ? half_data : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_xdma_iob_rd_downsize.sv
// Bench for xdma_iob_rd_downsize: table of read transactions plus hand-written
// reset, invalid-mode and reset-in-WAIT sequences. A behavioural SRAM model
// answers each read strobe after 1+lat_extra cycles with data derived from
// (bank, line, generation, half); generations are bumped to model IOB writes.
module tb_xdma_iob_rd_downsize;

`ifdef XDMA_RD_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic         xclk = 1'b0;
  logic         xreset_n;
  logic [3:0]   dma_mode;
  logic [31:0]  maddr;
  logic         mread;
  logic         saccept, svalid, slast;
  logic [127:0] sdata;
  logic         mready;
  logic         iob_inval;
  logic [11:0]  iob0_addr, iob1_addr;
  logic         iob0_read, iob0_cs, iob1_read, iob1_cs;
  logic [255:0] iob0_rdata, iob1_rdata;
  logic         iob0_dready, iob1_dready;
  logic [1:0]   dbg_state;

  xdma_iob_rd_downsize dut (
    .xclk(xclk), .xreset_n(xreset_n), .dma_mode(dma_mode), .maddr(maddr),
    .mread(mread), .saccept(saccept), .svalid(svalid), .slast(slast),
    .sdata(sdata), .mready(mready), .iob_inval(iob_inval),
    .iob0_addr(iob0_addr), .iob0_read(iob0_read), .iob0_cs(iob0_cs),
    .iob0_rdata(iob0_rdata), .iob0_dready(iob0_dready),
    .iob1_addr(iob1_addr), .iob1_read(iob1_read), .iob1_cs(iob1_cs),
    .iob1_rdata(iob1_rdata), .iob1_dready(iob1_dready),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 xclk = ~xclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_half(input bit b, input logic [11:0] line,
                                            input int g, input bit h);
    return {31'd0, b, 32'(g), 20'd0, line, 31'd0, h};
  endfunction

  // SRAM model
  int          gen [2];
  int          lat_extra = 0;
  int          cnt0 = 0, cnt1 = 0;
  int          rd_cnt0 = 0, rd_cnt1 = 0;
  int          cs_err = 0;
  logic [11:0] a0 = '0, a1 = '0;
  logic        m_dready0 = 1'b0, m_dready1 = 1'b0;
  logic        inj0 = 1'b0, inj1 = 1'b0;

  assign iob0_dready = m_dready0 | inj0;
  assign iob1_dready = m_dready1 | inj1;

  always @(negedge xclk) begin
    m_dready0 = 1'b0;
    m_dready1 = 1'b0;
    if (iob0_cs !== iob0_read || iob1_cs !== iob1_read) cs_err++;
    if (cnt0 != 0) begin
      cnt0--;
      if (cnt0 == 0) begin
        m_dready0  = 1'b1;
        iob0_rdata = {exp_half(1'b0, a0, gen[0], 1'b1), exp_half(1'b0, a0, gen[0], 1'b0)};
      end
    end
    if (cnt1 != 0) begin
      cnt1--;
      if (cnt1 == 0) begin
        m_dready1  = 1'b1;
        iob1_rdata = {exp_half(1'b1, a1, gen[1], 1'b1), exp_half(1'b1, a1, gen[1], 1'b0)};
      end
    end
    if (iob0_read === 1'b1) begin
      cnt0 = 1 + lat_extra; a0 = iob0_addr; rd_cnt0++;
    end
    if (iob1_read === 1'b1) begin
      cnt1 = 1 + lat_extra; a1 = iob1_addr; rd_cnt1++;
    end
  end

  // driver tasks
  task automatic pulse_inval(input bit bank);
    @(negedge xclk);
    iob_inval = 1'b1;
    gen[bank]++;
    @(negedge xclk);
    iob_inval = 1'b0;
  endtask

  task automatic run_txn(input int idx, input logic [3:0] mode, input logic [31:0] addr,
                         input bit exp_miss, input int extra, input int stall,
                         input bit spur, input bit inval_wait);
    bit           bank;
    logic [11:0]  line;
    logic [127:0] exp_d;
    logic [127:0] held;
    int           r0, r1, lat;
    bank  = (mode == 4'b0100);
    line  = addr[12:1];
    exp_d = exp_half(bank, line, gen[bank], addr[0]);
    r0 = rd_cnt0;
    r1 = rd_cnt1;
    lat_extra = extra;
    // accept cycle T
    @(negedge xclk);
    dma_mode = mode; maddr = addr; mread = 1'b1;
    #1 chk($sformatf("r%0d_saccept", idx), 128'(saccept), 128'd1);
    // T+1: mode scrambled to show it is only sampled at accept
    @(negedge xclk);
    mread = 1'b0; dma_mode = 4'hF;
    if (spur) begin
      if (bank) inj0 = 1'b1; else inj1 = 1'b1;
    end
    lat = 1;
    #1;
    if (exp_miss) begin
      chk($sformatf("r%0d_strobe", idx), 128'(bank ? iob1_read : iob0_read), 128'd1);
      chk($sformatf("r%0d_addr", idx), 128'(bank ? iob1_addr : iob0_addr), 128'(line));
      chk($sformatf("r%0d_other_idle", idx), 128'(bank ? iob0_read : iob1_read), 128'd0);
    end
    while (svalid !== 1'b1 && lat < 20) begin
      @(negedge xclk);
      iob_inval = inval_wait && (lat + 1 == 2 + extra);
      dma_mode  = mode;
      #1 lat++;
    end
    iob_inval = 1'b0;
    chk($sformatf("r%0d_latency", idx), 128'(lat), 128'(exp_miss ? 3 + extra : 1));
    chk($sformatf("r%0d_sdata", idx), sdata, exp_d);
    chk($sformatf("r%0d_slast", idx), 128'(slast), 128'd1);
    held = sdata;
    // backpressure with a new request pending
    for (int i = 0; i < stall; i++) begin
      @(negedge xclk);
      dma_mode = mode; mread = 1'b1;
      #1;
      chk($sformatf("r%0d_stall%0d", idx, i),
          {svalid, saccept, iob0_read, iob1_read, sdata[123:0]},
          {4'b1000, held[123:0]});
    end
    @(negedge xclk);
    mready = 1'b1;
    #1 chk($sformatf("r%0d_mready_cyc", idx), {svalid, saccept, sdata}, {2'b10, held});
    @(negedge xclk);
    mready = 1'b0; mread = 1'b0; inj0 = 1'b0; inj1 = 1'b0;
    #1 chk($sformatf("r%0d_done", idx), 128'(svalid), 128'd0);
    chk($sformatf("r%0d_reads_sel", idx), 128'(bank ? rd_cnt1 - r1 : rd_cnt0 - r0),
        128'(exp_miss));
    chk($sformatf("r%0d_reads_other", idx), 128'(bank ? rd_cnt0 - r0 : rd_cnt1 - r1), 128'd0);
  endtask

  // vector table
  typedef struct {
    logic [3:0]  mode;
    logic [31:0] addr;
    bit          inval;
    bit          miss_lb;
    bit          miss_nolb;
    int          extra;
    int          stall;
    bit          spur;
    bit          inval_wait;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int sv_seen;
    int r0, r1;
    gen[0] = 0; gen[1] = 0;
    iob0_rdata = '0; iob1_rdata = '0;
    //            mode     addr           inv lbm nlbm ext stl spr invw
    tbl[0]  = '{4'b0011, 32'h0000_000A, 0, 1, 1, 0, 0, 0, 0}; // miss IOB0 line 5 lo
    tbl[1]  = '{4'b0011, 32'h0000_000B, 0, 0, 1, 0, 5, 0, 0}; // other half + stall
    tbl[2]  = '{4'b0011, 32'h0000_000A, 0, 0, 1, 0, 0, 0, 0}; // same half again
    tbl[3]  = '{4'b0011, 32'h0000_000B, 1, 1, 1, 0, 0, 0, 0}; // after invalidate
    tbl[4]  = '{4'b0100, 32'h0000_000A, 0, 1, 1, 2, 0, 1, 0}; // bank swap, slow SRAM, stray dready
    tbl[5]  = '{4'b0100, 32'h0000_000B, 0, 0, 1, 0, 0, 0, 0}; // IOB1 other half
    tbl[6]  = '{4'b0011, 32'h0000_000B, 0, 1, 1, 0, 0, 0, 0}; // back to IOB0
    tbl[7]  = '{4'b0011, 32'h0000_1FFF, 0, 1, 1, 0, 0, 0, 0}; // top line, hi half
    tbl[8]  = '{4'b0011, 32'h0000_1FFE, 0, 0, 1, 0, 2, 0, 0}; // top line, lo half
    tbl[9]  = '{4'b0011, 32'hFFFF_E00A, 0, 1, 1, 0, 0, 0, 0}; // upper addr bits ignored
    tbl[10] = '{4'b0011, 32'h0000_0014, 0, 1, 1, 0, 0, 0, 1}; // inval during capture
    tbl[11] = '{4'b0011, 32'h0000_0015, 0, 1, 1, 0, 0, 0, 0}; // must miss afterwards

    // clock / reset block
    xreset_n = 1'b0; dma_mode = 4'h0; maddr = '0; mread = 1'b0;
    mready = 1'b0; iob_inval = 1'b0;
    repeat (2) @(negedge xclk);
    #1;
    chk("rst_saccept", 128'(saccept), 128'd0);
    chk("rst_svalid", 128'(svalid), 128'd0);
    chk("rst_slast", 128'(slast), 128'd0);
    chk("rst_sdata", sdata, 128'd0);
    chk("rst_strobes", {iob0_read, iob0_cs, iob1_read, iob1_cs}, 128'd0);
    chk("rst_addr", {iob0_addr, iob1_addr}, 128'd0);
    chk("rst_state", 128'(dbg_state), 128'd0);
    @(negedge xclk);
    xreset_n = 1'b1;

    // invalid modes are never accepted
    r0 = rd_cnt0; r1 = rd_cnt1;
    @(negedge xclk);
    dma_mode = 4'b0101; maddr = 32'h0A; mread = 1'b1;
    #1 chk("badmode_0101", 128'(saccept), 128'd1 ^ 128'd1);
    @(negedge xclk);
    dma_mode = 4'b0000;
    #1 chk("badmode_0000", 128'(saccept), 128'd0);
    @(negedge xclk);
    mread = 1'b0;
    #1 chk("badmode_idle", {dbg_state, 30'(rd_cnt0 - r0), 30'(rd_cnt1 - r1)}, 128'd0);

    // table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].inval) pulse_inval(tbl[i].mode == 4'b0100);
      run_txn(i, tbl[i].mode, tbl[i].addr, LB ? tbl[i].miss_lb : tbl[i].miss_nolb,
              tbl[i].extra, tbl[i].stall, tbl[i].spur, tbl[i].inval_wait);
    end

    // reset asserted while waiting on a slow SRAM
    lat_extra = 3;
    @(negedge xclk);
    dma_mode = 4'b0011; maddr = 32'h0C; mread = 1'b1;
    @(negedge xclk);
    mread = 1'b0;
    @(negedge xclk);
    #1 chk("rstwait_in_wait", 128'(dbg_state), 128'd2);
    xreset_n = 1'b0;
    #1;
    chk("rstwait_outs", {svalid, slast, saccept, iob0_read, iob0_cs, iob1_read, iob1_cs,
                         iob0_addr, iob1_addr}, 128'd0);
    chk("rstwait_sdata", sdata, 128'd0);
    repeat (2) @(negedge xclk);
    xreset_n = 1'b1;
    lat_extra = 0;
    sv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge xclk);
      #1 if (svalid !== 1'b0) sv_seen++;
    end
    chk("rstwait_no_resp", 128'(sv_seen), 128'd0);
    // line 10 was buffered before reset; it must miss now
    run_txn(20, 4'b0011, 32'h0000_0015, 1'b1, 0, 0, 1'b0, 1'b0);

    chk("cs_equals_read", 128'(cs_err), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
